// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: byte-strobed R/W registers, read-only status
// mirrors on the top indices, per-register write pulse and SLVERR decode.
module axi4lite_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RO     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  input  logic [ADDR_WIDTH-1:0]                    S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                    S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                  S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                    S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                    S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0]           reg_out,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                      wr_pulse
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_WIDTH - OFF_W;
  localparam int RW_REGS = NUM_REGS - NUM_RO;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e                 wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  logic                    awready, wready, bvalid;
  logic                    aw_hs, w_hs, commit, cm_ok;
  logic [IDX_W-1:0]        cm_idx;

  rstate_e                 rstate_q, rstate_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    arready, rvalid, ar_hs, rd_err;
  logic [IDX_W-1:0]        ar_idx;
  logic [DATA_WIDTH-1:0]   rd_val;

  logic [DATA_WIDTH-1:0]   reg_view [NUM_REGS];
  logic                    unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_d[OFF_W-1:0],
                       S_AXI_ARADDR[OFF_W-1:0], status_in};

  // ---------------- write path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q   <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        wstate_d = W_RESP;
        commit   = 1'b1;
      end
      W_HAVE_W: if (aw_hs) begin
        wstate_d = W_RESP;
        commit   = 1'b1;
      end
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wstate_q)
      W_IDLE:    begin awready = 1'b1; wready = 1'b1; end
      W_HAVE_AW: wready  = 1'b1;
      W_HAVE_W:  awready = 1'b1;
      W_RESP:    bvalid  = 1'b1;
      default:   ;
    endcase
    if (ARESET) begin
      awready = 1'b0;
      wready  = 1'b0;
    end
  end

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID && wready;

  // The *_d capture values double as the commit operands: they already pick
  // the live bus value when that channel handshakes on the commit edge.
  always_comb begin
    awaddr_d = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata_d  = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d  = w_hs ? S_AXI_WSTRB : wstrb_q;
    cm_idx   = awaddr_d[ADDR_WIDTH-1:OFF_W];
    cm_ok    = int'(cm_idx) < RW_REGS;
    bresp_d  = commit ? (cm_ok ? 2'b00 : 2'b10) : bresp_q;
    for (int k = 0; k < NUM_REGS; k++)
      wr_pulse_d[k] = commit && cm_ok && (int'(cm_idx) == k);
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    if (k < RW_REGS) begin : g_rw
      logic [DATA_WIDTH-1:0] val_q, val_d;
      always_comb begin
        val_d = val_q;
        if (wr_pulse_d[k])
          for (int b = 0; b < STRB_W; b++)
            if (wstrb_d[b]) val_d[b*8 +: 8] = wdata_d[b*8 +: 8];
      end
      always_ff @(posedge ACLK) begin
        if (ARESET) val_q <= RESET_VALUE;
        else        val_q <= val_d;
      end
      assign reg_view[k] = val_q;
    end else begin : g_ro
      assign reg_view[k] = status_in[(k-RW_REGS)*DATA_WIDTH +: DATA_WIDTH];
    end
    assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = reg_view[k];
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign wr_pulse      = wr_pulse_q;

  // ---------------- read path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // Lookup reads the current register value, so a same-edge write is not seen.
  always_comb begin
    ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:OFF_W];
    rd_val = '0;
    rd_err = 1'b1;
    for (int k = 0; k < NUM_REGS; k++)
      if (int'(ar_idx) == k) begin
        rd_val = reg_view[k];
        rd_err = 1'b0;
      end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rstate_d = R_DATA;
        rdata_d  = rd_val;
        rresp_d  = rd_err ? 2'b10 : 2'b00;
      end
      R_DATA: if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (rstate_q == R_IDLE) && !ARESET;
    rvalid  = (rstate_q == R_DATA);
  end

  assign ar_hs         = S_AXI_ARVALID && arready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Self-checking bench for axi4lite_regbank (32-bit, 8 regs, 2 read-only):
// vector table, hand sequences for ordering/backpressure/reset, random ops vs model.
module tb_axi4lite_regbank;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [7:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [255:0] reg_out;
  logic [63:0]  status_in;
  logic [7:0]   wr_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [6];

  axi4lite_regbank #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(8), .NUM_RO(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // ---- reference model: registers as plain words, byte-lane merge by arithmetic
  function automatic void m_reset();
    for (int k = 0; k < 6; k++) mdl[k] = 32'h0;
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                                  output logic [1:0] resp, output logic [7:0] pulse);
    int idx = int'(a) / 4;
    resp = 2'b10; pulse = 8'h0;
    if (idx < 6) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      resp = 2'b00; pulse = 8'(1 << idx);
    end
  endfunction

  function automatic void m_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int idx = int'(a) / 4;
    d = 32'h0; resp = 2'b00;
    if (idx >= 8)      resp = 2'b10;
    else if (idx >= 6) d = status_in[(idx-6)*32 +: 32];
    else               d = mdl[idx];
  endfunction

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int k = 0; k < 6; k++) f[k*32 +: 32] = mdl[k];
    f[192 +: 64] = status_in;
    return f;
  endfunction

  // ---- bus tasks: entered and left 1 time unit after a rising edge
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [7:0] p_at, output logic [7:0] p_after);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    resp = 2'b11; p_at = 8'hxx; p_after = 8'hxx;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1; cyc++;
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  S_AXI_WVALID  = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      timeout("write_handshake");
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    check("bvalid_after_commit", S_AXI_BVALID, 1);
    resp = S_AXI_BRESP; p_at = wr_pulse;
    @(posedge ACLK); #1;
    check("bvalid_cleared", S_AXI_BVALID, 0);
    p_after = wr_pulse;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int cyc = 0;
    bit done = 0, hs;
    d = 32'hxxxxxxxx; resp = 2'b11;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!done && cyc < 20) begin
      hs = S_AXI_ARREADY;
      @(posedge ACLK); #1; cyc++;
      if (hs) done = 1;
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) begin timeout("read_handshake"); return; end
    check("rvalid_after_ar", S_AXI_RVALID, 1);
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    check("rvalid_cleared", S_AXI_RVALID, 0);
  endtask

  typedef struct {
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [7:0]  pulse;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  initial begin
    vec_t vecs [11];
    logic [1:0]  resp, mresp, rresp;
    logic [7:0]  p_at, p_after, mpulse;
    logic [31:0] rd, md, pre;

    vecs[0]  = '{8'h00, 32'h1,        4'hF, 2'b00, 8'h01, 8'h00, 32'h1,        2'b00};
    vecs[1]  = '{8'h04, 32'h2,        4'hF, 2'b00, 8'h02, 8'h04, 32'h2,        2'b00};
    vecs[2]  = '{8'h08, 32'h3,        4'hF, 2'b00, 8'h04, 8'h08, 32'h3,        2'b00};
    vecs[3]  = '{8'h0C, 32'h4,        4'hF, 2'b00, 8'h08, 8'h0C, 32'h4,        2'b00};
    vecs[4]  = '{8'h08, 32'h11223344, 4'hF, 2'b00, 8'h04, 8'h08, 32'h11223344, 2'b00};
    vecs[5]  = '{8'h08, 32'hAABBCCDD, 4'h5, 2'b00, 8'h04, 8'h08, 32'h11BB33DD, 2'b00};
    vecs[6]  = '{8'h40, 32'h12345678, 4'hF, 2'b10, 8'h00, 8'h40, 32'h0,        2'b10};
    vecs[7]  = '{8'h1C, 32'h55,       4'hF, 2'b10, 8'h00, 8'h1C, 32'hCAFE0001, 2'b00};
    vecs[8]  = '{8'h13, 32'hA5A5A5A5, 4'hF, 2'b00, 8'h10, 8'h10, 32'hA5A5A5A5, 2'b00};
    vecs[9]  = '{8'h17, 32'hFFFFFFFF, 4'h0, 2'b00, 8'h20, 8'h14, 32'h0,        2'b00};
    vecs[10] = '{8'h18, 32'h9,        4'hF, 2'b10, 8'h00, 8'h18, 32'h5A5A0000, 2'b00};

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    status_in = {32'hCAFE0001, 32'h5A5A0000};
    m_reset();

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready",  S_AXI_WREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid",  S_AXI_BVALID, 0);
    check("rst_rvalid",  S_AXI_RVALID, 0);
    check("rst_bresp",   S_AXI_BRESP, 0);
    check("rst_rresp",   S_AXI_RRESP, 0);
    check("rst_rdata",   S_AXI_RDATA, 0);
    check("rst_pulse",   wr_pulse, 0);
    check("rst_reg_out", reg_out, m_flat());
    ARESET = 1'b0;
    #1;
    check("idle_awready", S_AXI_AWREADY, 1);
    check("idle_wready",  S_AXI_WREADY, 1);
    check("idle_arready", S_AXI_ARREADY, 1);
    @(posedge ACLK); #1;

    // table: write, then read back
    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, resp, p_at, p_after);
      m_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, mresp, mpulse);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
      check($sformatf("vec%0d_pulse", i), p_at, vecs[i].pulse);
      check($sformatf("vec%0d_pulse_off", i), p_after, 0);
      check($sformatf("vec%0d_reg_out", i), reg_out, m_flat());
      do_read(vecs[i].raddr, rd, rresp);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_rresp", i), rresp, vecs[i].rresp);
    end

    // W arrives three cycles ahead of AW
    S_AXI_BREADY = 1'b1;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("wfirst_awready", S_AXI_AWREADY, 1);
      check("wfirst_wready",  S_AXI_WREADY, 0);
      check("wfirst_bvalid",  S_AXI_BVALID, 0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWADDR = 8'h10; S_AXI_AWVALID = 1'b1;
    check("wfirst_awready_late", S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    m_write(8'h10, 32'hDEADBEEF, 4'hF, mresp, mpulse);
    check("wfirst_bvalid_set", S_AXI_BVALID, 1);
    check("wfirst_bresp", S_AXI_BRESP, 2'b00);
    check("wfirst_pulse", wr_pulse, 8'h10);
    check("wfirst_reg4", reg_out[4*32 +: 32], 32'hDEADBEEF);
    @(posedge ACLK); #1;
    check("wfirst_bvalid_clr", S_AXI_BVALID, 0);
    check("wfirst_pulse_clr", wr_pulse, 0);

    // B backpressure with a concurrent read and a queued second write
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 8'h14; S_AXI_WDATA = 32'h5555AAAA; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    m_write(8'h14, 32'h5555AAAA, 4'hF, mresp, mpulse);
    S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h77;
    S_AXI_ARADDR = 8'h14; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bhold%0d_bvalid", i), S_AXI_BVALID, 1);
      check($sformatf("bhold%0d_bresp", i), S_AXI_BRESP, 2'b00);
      check($sformatf("bhold%0d_awready", i), S_AXI_AWREADY, 0);
      check($sformatf("bhold%0d_wready", i), S_AXI_WREADY, 0);
      @(posedge ACLK); #1;
      if (i == 0) begin
        S_AXI_ARVALID = 1'b0;
        check("bhold_rvalid", S_AXI_RVALID, 1);
        check("bhold_rdata", S_AXI_RDATA, 32'h5555AAAA);
        check("bhold_rresp", S_AXI_RRESP, 2'b00);
      end
      if (i == 1) check("bhold_rvalid_clr", S_AXI_RVALID, 0);
    end
    S_AXI_BREADY = 1'b1;
    check("bhold_bvalid_last", S_AXI_BVALID, 1);
    @(posedge ACLK); #1;
    check("bhold_release_bvalid", S_AXI_BVALID, 0);
    check("bhold_release_awready", S_AXI_AWREADY, 1);
    check("bhold_release_wready", S_AXI_WREADY, 1);
    check("bhold_reg0_untouched", reg_out, m_flat());
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    m_write(8'h00, 32'h77, 4'hF, mresp, mpulse);
    check("second_bvalid", S_AXI_BVALID, 1);
    check("second_pulse", wr_pulse, 8'h01);
    check("second_reg_out", reg_out, m_flat());
    @(posedge ACLK); #1;

    // randomized traffic against the model
    status_in = {$urandom, $urandom};
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  a = 8'($urandom_range(0, 8'h47));
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, d, s, resp, p_at, p_after);
        m_write(a, d, s, mresp, mpulse);
        check($sformatf("rnd%0d_bresp", i), resp, mresp);
        check($sformatf("rnd%0d_pulse", i), p_at, mpulse);
        check($sformatf("rnd%0d_reg_out", i), reg_out, m_flat());
      end else begin
        do_read(a, rd, rresp);
        m_read(a, md, mresp);
        check($sformatf("rnd%0d_rdata", i), rd, md);
        check($sformatf("rnd%0d_rresp", i), rresp, mresp);
      end
    end

    // same-edge read/write of reg1, then reset while both responses pending
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    m_read(8'h04, pre, mresp);
    S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'hBEEF0004; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    m_write(8'h04, 32'hBEEF0004, 4'hF, mresp, mpulse);
    check("coll_bvalid", S_AXI_BVALID, 1);
    check("coll_rvalid", S_AXI_RVALID, 1);
    check("coll_rdata_prewrite", S_AXI_RDATA, pre);
    check("coll_reg1", reg_out[1*32 +: 32], 32'hBEEF0004);
    ARESET = 1'b1;
    #1;
    check("arst_awready", S_AXI_AWREADY, 0);
    check("arst_wready", S_AXI_WREADY, 0);
    check("arst_arready", S_AXI_ARREADY, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    m_reset();
    check("arst_bvalid", S_AXI_BVALID, 0);
    check("arst_rvalid", S_AXI_RVALID, 0);
    check("arst_rdata", S_AXI_RDATA, 0);
    check("arst_pulse", wr_pulse, 0);
    check("arst_reg_out", reg_out, m_flat());
    do_write(8'h00, 32'h600D600D, 4'hF, resp, p_at, p_after);
    m_write(8'h00, 32'h600D600D, 4'hF, mresp, mpulse);
    check("post_rst_bresp", resp, 2'b00);
    check("post_rst_pulse", p_at, 8'h01);
    do_read(8'h00, rd, rresp);
    check("post_rst_rdata", rd, 32'h600D600D);
    check("post_rst_rresp", rresp, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4lite_regbank.md
Name: axi4lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank. It is the next-generation replacement for the fixed four-register S00_AXI slave inside IP_wrapper.
- Generalised in data width and register count. Adds byte strobes, independent AW/W ordering, read-only status registers, a per-register write-strobe pulse, and SLVERR decode.
- Sits behind the master VIP in the wrapper block design and drives IP configuration.

Parameters:
- DATA_WIDTH, 32: AXI data width. Legal values are 32 or 64.
- NUM_REGS, 8: total registers, 2..64.
- ADDR_WIDTH, 8: AXI address width. Must be >= clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
- NUM_RO, 2: the top NUM_RO register indices are read-only and mirror status_in. Range 0..NUM_REGS-1.
- RESET_VALUE, 0: reset value of every read/write register.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1.  S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  DATA_WIDTH.  S_AXI_WSTRB  in  DATA_WIDTH/8.
- S_AXI_WVALID  in  1.  S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2.  S_AXI_BVALID  out  1.  S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_WIDTH.  S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1.  S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  DATA_WIDTH.  S_AXI_RRESP  out  2.
- S_AXI_RVALID  out  1.  S_AXI_RREADY  in  1.
- reg_out  out  NUM_REGS*DATA_WIDTH  flat register contents; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- status_in  in  max(1,NUM_RO)*DATA_WIDTH  values for the read-only registers; RO slot j maps to register index NUM_REGS-NUM_RO+j.
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on a successful write.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset state:
  - All R/W registers = RESET_VALUE.
  - BVALID, RVALID, wr_pulse = 0; BRESP, RRESP = 0; RDATA = 0.
  - All READY outputs = 0 while ARESET = 1.
- Address decode: idx = addr[ADDR_WIDTH-1 : clog2(DATA_WIDTH/8)]. Low byte-offset bits are ignored. idx >= NUM_REGS is out of range.
- Write FSM states:
  - W_IDLE: AWREADY = 1, WREADY = 1.
  - W_HAVE_AW: AWREADY = 0, WREADY = 1.
  - W_HAVE_W: AWREADY = 1, WREADY = 0.
  - W_RESP: both READYs = 0, BVALID = 1.
- Write transitions:
  - W_IDLE: AW only -> W_HAVE_AW. W only -> W_HAVE_W. Both in the same cycle -> W_RESP.
  - W_HAVE_AW/W_HAVE_W: missing channel handshakes -> W_RESP.
  - W_RESP -> W_IDLE on BREADY. BVALID and BRESP are held stable until then.
- Write commit, at edge N (the edge that completes the second of the AW/W handshakes):
  - In range and R/W: byte lanes with WSTRB set update the register; other lanes hold. wr_pulse[idx] = 1 for exactly the cycle after edge N. BRESP = OKAY (00).
  - Out of range, or RO register: no state change, no pulse, BRESP = SLVERR (10).
  - BVALID is visible in the cycle after edge N.
- Write limits: only one write is outstanding. No new AW or W is accepted while in W_RESP.
- Read FSM states:
  - R_IDLE: ARREADY = 1.
  - R_DATA: RVALID = 1, ARREADY = 0.
- Read transitions and data:
  - On the AR handshake, RDATA/RRESP are registered and the FSM moves to R_DATA.
  - RDATA is reg[idx], or status_in slot for RO registers, with RRESP = OKAY.
  - Out of range: RDATA = 0, RRESP = SLVERR.
  - R_DATA -> R_IDLE on RREADY. RDATA and RRESP are held stable until then.
- Simultaneous read/write: read and write paths are independent and may run concurrently. If an AR handshake and a write commit to the same register fall on the same edge, the read returns the pre-write value.
- Reset mid-transaction: any pending transaction is abandoned. BVALID/RVALID are 0 in the cycle after ARESET is sampled high; registers return to reset values.
- Latency: minimum write-to-BVALID 1 cycle; AR-to-RVALID 1 cycle. Throughput: one write per 2 cycles and one read per 2 cycles when READYs are held high.

Test Plan:
1. Reset, write 0x1..0x4 to 0x0/0x4/0x8/0xC with WSTRB=0xF, read back -> RDATA 0x1..0x4; all BRESP/RRESP = 00; wr_pulse[0..3] each high exactly 1 cycle.
2. WVALID (0xDEADBEEF) presented 3 cycles before AWVALID (0x10) -> WREADY accepts first, AWREADY stays 1; BVALID the cycle after the AW handshake; reg_out reg4 = 0xDEADBEEF.
3. reg2 = 0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x8 returns 0x11BB33DD.
4. Write 0x40 (idx 16, NUM_REGS=8) -> BRESP=10, no reg_out change, no wr_pulse. Read 0x40 -> RDATA=0, RRESP=10. Write to 0x1C (RO reg7) -> SLVERR. With status_in slot 1 = 0xCAFE0001, read 0x1C -> 0xCAFE0001, OKAY.
5. BREADY held low 5 cycles after a write -> BVALID/BRESP stable, AWREADY=WREADY=0; a second AW/W is not accepted until the cycle after BREADY. A read during the same window completes normally.
6. ARESET pulsed for 1 cycle while BVALID=1 and RVALID=1 -> both 0 the following cycle; reg_out = RESET_VALUE; subsequent write/read to 0x0 succeeds.
